// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice per clock, LSB first.
// A WIDTH-bit addition takes WIDTH RUN cycles plus one DONE cycle.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             slice_sum;
    logic             slice_carry;
    logic             last_bit;

    // Operands shift right, so the current bit always sits at position 0.
    always_comb begin
        slice_sum        = a_sh[0] ^ b_sh[0] ^ carry;
        slice_carry      = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last_bit         = (cnt == LAST);
        psum_next        = psum;
        psum_next[cnt]   = slice_sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status flags are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c;
                        cnt   <= '0;
                        psum  <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= slice_carry;
                    psum  <= psum_next;
                    if (last_bit) begin
                        sum  <= psum_next;
                        cout <= slice_carry;
                        cnt  <= '0;
                    end else begin
                        cnt  <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed vectors queue
// expected {cout,sum}; a negedge monitor pops one entry per done pulse.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int cycle = 0;
    int last_done_cycle = 0;
    bit have_last_done = 1'b0;
    bit burst = 1'b0;

    logic [W:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [W:0] e;
        cycle++;
        if (done) begin
            done_count++;
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL busy_and_done: busy=%0b done=%0b required busy=0", busy, done);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got {cout,sum}=%h with no result pending", {cout, sum});
            end else begin
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    errors++;
                    $display("FAIL result: got {cout,sum}=%h required %h", {cout, sum}, e);
                end
            end
            if (burst) begin
                if (have_last_done) begin
                    checks++;
                    if (cycle - last_done_cycle != W + 2) begin
                        errors++;
                        $display("FAIL burst_period: got %0d cycles required %0d",
                                 cycle - last_done_cycle, W + 2);
                    end
                end
                have_last_done  = 1'b1;
                last_done_cycle = cycle;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        logic [W:0] e;
        int lat;
        int bc;
        bit seen;
        e = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        @(negedge clk);
        a = ta; b = tb_; c = tc; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta; b = ~tb_; c = ~tc;
        lat = 0; bc = 0; seen = 1'b0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
            if (done) seen = 1'b1;
        end
        chk("latency", 32'(lat), 32'(W + 1));
        chk("busy_cycles", 32'(bc), 32'(W));
        repeat (3) @(negedge clk);
        chk("sum_hold", 32'({cout, sum}), 32'(e));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    typedef struct { logic [W-1:0] ta; logic [W-1:0] tb_; logic tc; } vec_t;

    initial begin
        vec_t vecs[6];
        vec_t bv[6];
        int dc0;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);

        vecs[0] = '{8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1};
        vecs[3] = '{8'h3C, 8'h0F, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1};
        foreach (vecs[i]) run_op(vecs[i].ta, vecs[i].tb_, vecs[i].tc);

        // start pulses during RUN and DONE must be ignored
        dc0 = done_count;
        @(negedge clk);
        a = 8'h10; b = 8'h20; c = 1'b0; start = 1'b1;
        exp_q.push_back(9'h030);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ignored_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("ignored_pulses", 32'(done_count - dc0), 32'd1);
        chk("ignored_sum", 32'({cout, sum}), 32'h030);

        // reset mid-RUN discards the operation
        dc0 = done_count;
        @(negedge clk);
        a = 8'h55; b = 8'h11; c = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        repeat (12) @(negedge clk);
        chk("midrst_no_done", 32'(done_count - dc0), 32'd0);
        run_op(8'h01, 8'h01, 1'b1);

        // start held high: one result every W+2 cycles
        bv[0] = '{8'h12, 8'h34, 1'b0};
        bv[1] = '{8'hF0, 8'h0F, 1'b1};
        bv[2] = '{8'h7F, 8'h01, 1'b0};
        bv[3] = '{8'hC3, 8'h99, 1'b1};
        bv[4] = '{8'h00, 8'hFF, 1'b1};
        bv[5] = '{8'h6E, 8'h2D, 1'b0};
        dc0 = done_count;
        burst = 1'b1;
        have_last_done = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            a = bv[k].ta; b = bv[k].tb_; c = bv[k].tc; start = 1'b1;
            exp_q.push_back({1'b0, bv[k].ta} + {1'b0, bv[k].tb_} + {{W{1'b0}}, bv[k].tc});
            @(posedge clk);
            #1;
            if (k == 5) begin
                start = 1'b0;
            end else begin
                repeat (3) @(negedge clk);
                a = ~bv[k].ta; b = bv[k].ta; c = ~bv[k].tc;
                repeat (7) @(negedge clk);
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("burst_drained", 32'(exp_q.size()), 32'd0);
        chk("burst_pulses", 32'(done_count - dc0), 32'd6);
        burst = 1'b0;
        repeat (12) @(negedge clk);
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
